// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG entropy back end.
// Code/accumulator widths, length width and marker bytes.
package jpeg_pkg;

  localparam int CODE_W = 32;
  localparam int ACC_W  = 64;
  localparam int LEN_W  = 6;

  localparam logic [7:0] MARKER_FF = 8'hFF;
  localparam logic [7:0] STUFF_00  = 8'h00;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register; with JPEG_BYTESTUFF_EN it inserts 0x00 after 0xFF
// and stalls the extractor for that cycle.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clock,
  input  logic       nreset,
  input  logic       push,
  input  logic [7:0] value,
  output logic       stall,
  output logic       data_out_valid,
  output logic [7:0] data_out
);

`ifdef JPEG_BYTESTUFF_EN
  logic pending;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      data_out_valid <= 1'b0;
      data_out       <= 8'h00;
      pending        <= 1'b0;
    end else if (pending) begin
      data_out_valid <= 1'b1;
      data_out       <= STUFF_00;
      pending        <= 1'b0;
    end else if (push) begin
      data_out_valid <= 1'b1;
      data_out       <= value;
      pending        <= (value == MARKER_FF);
    end else begin
      data_out_valid <= 1'b0;
    end
  end

  assign stall = pending;
`else
  always_ff @(posedge clock) begin
    if (!nreset) begin
      data_out_valid <= 1'b0;
      data_out       <= 8'h00;
    end else if (push) begin
      data_out_valid <= 1'b1;
      data_out       <= value;
    end else begin
      data_out_valid <= 1'b0;
    end
  end

  assign stall = 1'b0;
`endif

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length codes into an MSB-first byte stream.
// Define JPEG_BYTESTUFF_EN to insert 0x00 after every 0xFF byte.
module jpeg_bitstream_packer #(
  parameter int CODE_W = jpeg_pkg::CODE_W,
  parameter int ACC_W  = jpeg_pkg::ACC_W
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              data_in_valid,
  input  logic [CODE_W-1:0] data_in,
  input  logic [5:0]        input_length,
  input  logic              flush,
  output logic              data_in_ready,
  output logic              data_out_valid,
  output logic [7:0]        data_out
);
  import jpeg_pkg::*;

  localparam int FILL_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]  acc, acc_s, acc_a, acc_n;
  logic [ACC_W-1:0]  code_al, pad_al;
  logic [FILL_W-1:0] fill, fill_s, fill_a, fill_n;
  logic [FILL_W-1:0] sh;
  logic [LEN_W-1:0]  len;
  logic [CODE_W-1:0] code_m;
  logic [2:0]        pad;
  logic              extract, accept, stall;

  assign data_in_ready = (fill <= FILL_W'(ACC_W - CODE_W));
  assign accept  = data_in_valid && data_in_ready;
  assign extract = (fill >= FILL_W'(8)) && !stall;

  always_comb begin
    len = (input_length > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : input_length;
    if (!accept) len = '0;
    code_m = data_in & ~({CODE_W{1'b1}} << len);

    acc_s  = extract ? (acc << 8) : acc;
    fill_s = extract ? (fill - FILL_W'(8)) : fill;

    // Left-align the code, then drop it just below the surviving bits.
    sh      = FILL_W'(ACC_W) - FILL_W'(len);
    code_al = ({{(ACC_W-CODE_W){1'b0}}, code_m} << sh) >> fill_s;
    acc_a   = acc_s | code_al;
    fill_a  = fill_s + FILL_W'(len);

    pad    = ~fill_a[2:0] + 3'd1;
    pad_al = ~({ACC_W{1'b1}} >> pad) >> fill_a;

    acc_n  = acc_a;
    fill_n = fill_a;
    if (flush) begin
      acc_n  = acc_a | pad_al;
      fill_n = fill_a + FILL_W'(pad);
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_n;
      fill <= fill_n;
    end
  end

  jpeg_byte_stuffer u_stuffer (
    .clock          (clock),
    .nreset         (nreset),
    .push           (extract),
    .value          (acc[ACC_W-1 -: 8]),
    .stall          (stall),
    .data_out_valid (data_out_valid),
    .data_out       (data_out)
  );

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: bit-queue reference model,
// directed cases then randomized traffic.
module tb_jpeg_bitstream_packer;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [5:0]  input_length = '0;
  logic        flush = 1'b0;
  logic        data_in_ready;
  logic        data_out_valid;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  bit         q[$];
  bit         pend = 1'b0;
  bit         exp_v = 1'b0;
  logic [7:0] exp_b = 8'h00;
  logic [7:0] out_log[$];
  bit         ready_low_seen;

  jpeg_bitstream_packer dut (
    .clock          (clock),
    .nreset         (nreset),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .input_length   (input_length),
    .flush          (flush),
    .data_in_ready  (data_in_ready),
    .data_out_valid (data_out_valid),
    .data_out       (data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input int len,
                      input bit f, input bit rst);
    bit rdy_m;
    int l;
    logic [7:0] b;
    data_in_valid = v;
    data_in       = d;
    input_length  = 6'(len);
    flush         = f;
    nreset        = !rst;
    rdy_m = (q.size() <= 32);
    if (rst) begin
      q.delete();
      pend  = 1'b0;
      exp_v = 1'b0;
    end else begin
      exp_v = 1'b0;
      if (pend) begin
        exp_v = 1'b1;
        exp_b = 8'h00;
        pend  = 1'b0;
      end else if (q.size() >= 8) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], q.pop_front()};
        exp_v = 1'b1;
        exp_b = b;
`ifdef JPEG_BYTESTUFF_EN
        pend = (b == 8'hFF);
`endif
      end
      if (v && rdy_m) begin
        l = (len > 32) ? 32 : len;
        for (int i = l - 1; i >= 0; i--) q.push_back(d[i]);
      end
      if (f) while (q.size() % 8 != 0) q.push_back(1'b1);
    end
    @(posedge clock);
    #1;
    chk("ready", 64'(data_in_ready), 64'(q.size() <= 32));
    chk("valid", 64'(data_out_valid), 64'(exp_v));
    if (exp_v) chk("byte", 64'(data_out), 64'(exp_b));
    if (rst) chk("rst_byte", 64'(data_out), 64'h0);
    if (!data_in_ready) ready_low_seen = 1'b1;
    if (data_out_valid) out_log.push_back(data_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  initial begin : main
    bit bits8[8];
    int n_acc;
    logic [7:0] pat[4];
    bit v;
    int len;
    logic [31:0] d;

    bits8 = '{1, 1, 0, 1, 0, 0, 1, 0};
    pat   = '{8'h12, 8'h34, 8'h56, 8'h78};

    step(1'b0, 32'h0, 0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1);
    chk("reset_ready", 64'(data_in_ready), 64'h1);
    chk("reset_valid", 64'(data_out_valid), 64'h0);

    // Eight single-bit codes -> 0xD2
    out_log.delete();
    for (int i = 0; i < 8; i++)
      step(1'b1, {31'h0, bits8[i]}, 1, 1'b0, 1'b0);
    chk("d2_not_early", 64'(out_log.size()), 64'h0);
    idle(1);
    chk("d2_count", 64'(out_log.size()), 64'h1);
    if (out_log.size() > 0) chk("d2_value", 64'(out_log[0]), 64'hD2);
    idle(2);

    // 0x3FF len 10, then flush
    out_log.delete();
    step(1'b1, 32'h3FF, 10, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b1, 1'b0);
    idle(6);
`ifdef JPEG_BYTESTUFF_EN
    chk("ff_count", 64'(out_log.size()), 64'h4);
    if (out_log.size() == 4) begin
      chk("ff_b0", 64'(out_log[0]), 64'hFF);
      chk("ff_b1", 64'(out_log[1]), 64'h00);
      chk("ff_b2", 64'(out_log[2]), 64'hFF);
      chk("ff_b3", 64'(out_log[3]), 64'h00);
    end
`else
    chk("ff_count", 64'(out_log.size()), 64'h2);
    if (out_log.size() == 2) begin
      chk("ff_b0", 64'(out_log[0]), 64'hFF);
      chk("ff_b1", 64'(out_log[1]), 64'hFF);
    end
`endif

    // Back-to-back 32-bit codes
    out_log.delete();
    ready_low_seen = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      v = (q.size() <= 32);
      if (v) n_acc++;
      step(v, 32'h12345678, 32, 1'b0, 1'b0);
    end
    idle(20);
    chk("b2b_ready_drop", 64'(ready_low_seen), 64'h1);
    chk("b2b_count", 64'(out_log.size()), 64'(4 * n_acc));
    for (int i = 0; i < out_log.size(); i++)
      chk("b2b_order", 64'(out_log[i]), 64'(pat[i % 4]));

    // 3-bit 0b101 then flush -> 0xBF
    out_log.delete();
    step(1'b1, 32'hFFFF_FFFD, 3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b1, 1'b0);
    idle(3);
    chk("bf_count", 64'(out_log.size()), 64'h1);
    if (out_log.size() > 0) chk("bf_value", 64'(out_log[0]), 64'hBF);

    // Length 0 appends nothing
    out_log.delete();
    step(1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    idle(3);
    chk("len0_none", 64'(out_log.size()), 64'h0);

    // Reset with fill=20 and a stuff pending
    step(1'b1, 32'h0FFF_FFFF, 28, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1);
    chk("rst_mid_ready", 64'(data_in_ready), 64'h1);
    chk("rst_mid_valid", 64'(data_out_valid), 64'h0);
    out_log.delete();
    idle(4);
    chk("rst_mid_quiet", 64'(out_log.size()), 64'h0);

    // Randomized traffic including drops, flushes and resets
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(3) != 0);
      len = $urandom_range(40);
      d   = ($urandom_range(2) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(v, d, len, ($urandom_range(15) == 0),
           ($urandom_range(199) == 0));
    end
    idle(24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
